// File: rtl/alu_exec_unit.sv
// Handshaked integer execute stage: single-cycle ALU, 1-cycle multiply, iterative radix-2 divider.
// Optional feature macro: ALU_EXEC_MULDIV_EN builds the multiplier, divider and DIV state.
module alu_exec_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [4:0]      i_alu_op,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_illegal,
    output logic            o_busy
);
    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_AND    = 5'b00100;
    localparam logic [4:0] OP_OR     = 5'b00101;
    localparam logic [4:0] OP_XOR    = 5'b00110;
    localparam logic [4:0] OP_SLL    = 5'b00111;
    localparam logic [4:0] OP_SRL    = 5'b01000;
    localparam logic [4:0] OP_SRA    = 5'b01001;
    localparam logic [4:0] OP_SLTU   = 5'b01010;
    localparam logic [4:0] OP_SLT    = 5'b01011;
`ifdef ALU_EXEC_MULDIV_EN
    localparam logic [4:0] OP_MUL    = 5'b01100;
    localparam logic [4:0] OP_MULH   = 5'b01101;
    localparam logic [4:0] OP_MULHSU = 5'b10100;
    localparam logic [4:0] OP_MULHU  = 5'b10001;
    localparam logic [4:0] OP_DIV    = 5'b10010;
    localparam logic [4:0] OP_DIVU   = 5'b01110;
    localparam logic [4:0] OP_REM    = 5'b10011;
    localparam logic [4:0] OP_REMU   = 5'b01111;
    localparam int unsigned CNT_W    = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_result, w_result_nxt;
    logic            r_illegal, w_illegal_nxt;
    logic [XLEN-1:0] w_sc_res;
    logic            w_sc_ill;
    logic            w_start_div;
    logic            w_accept;

`ifdef ALU_EXEC_MULDIV_EN
    logic [XLEN-1:0]   r_rem, r_quo, r_dvs;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_neg_q, r_neg_r, r_is_rem;
    logic [XLEN-1:0]   w_rem_nxt, w_quo_nxt, w_dvs_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_neg_q_nxt, w_neg_r_nxt, w_is_rem_nxt;
    logic [2*XLEN-1:0] w_mul_a, w_mul_b, w_prod;
    logic              w_div_signed, w_div_is_rem;
    logic [XLEN-1:0]   w_abs_a, w_abs_b;
    logic [XLEN:0]     w_trial;
    logic [XLEN-1:0]   w_diff, w_rem_step, w_quo_step, w_q_fin, w_r_fin;
    logic              w_ge;

    // Operands sign- or zero-extended to 2*XLEN so one unsigned product covers all variants.
    always_comb begin
        w_mul_a = {{XLEN{1'b0}}, i_op_a};
        w_mul_b = {{XLEN{1'b0}}, i_op_b};
        if (i_alu_op == OP_MULH || i_alu_op == OP_MULHSU)
            w_mul_a = {{XLEN{i_op_a[XLEN-1]}}, i_op_a};
        if (i_alu_op == OP_MULH)
            w_mul_b = {{XLEN{i_op_b[XLEN-1]}}, i_op_b};
        w_prod = w_mul_a * w_mul_b;
    end

    assign w_div_signed = (i_alu_op == OP_DIV) || (i_alu_op == OP_REM);
    assign w_div_is_rem = (i_alu_op == OP_REM) || (i_alu_op == OP_REMU);
    assign w_abs_a      = (w_div_signed && i_op_a[XLEN-1]) ? (~i_op_a + XLEN'(1)) : i_op_a;
    assign w_abs_b      = (w_div_signed && i_op_b[XLEN-1]) ? (~i_op_b + XLEN'(1)) : i_op_b;

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign w_trial    = {r_rem, r_quo[XLEN-1]};
    assign w_ge       = w_trial >= {1'b0, r_dvs};
    assign w_diff     = w_trial[XLEN-1:0] - r_dvs;
    assign w_rem_step = w_ge ? w_diff : w_trial[XLEN-1:0];
    assign w_quo_step = {r_quo[XLEN-2:0], w_ge};
    assign w_q_fin    = r_neg_q ? (~w_quo_step + XLEN'(1)) : w_quo_step;
    assign w_r_fin    = r_neg_r ? (~w_rem_step + XLEN'(1)) : w_rem_step;
    assign o_busy     = (r_state == S_DIV);
`else
    assign o_busy     = 1'b0;
`endif

    // Single-cycle result decode; divider ops with special cases resolve here too.
    always_comb begin
        w_sc_res    = '0;
        w_sc_ill    = 1'b0;
        w_start_div = 1'b0;
        case (i_alu_op)
            OP_ADD:  w_sc_res = i_op_a + i_op_b;
            OP_SUB:  w_sc_res = i_op_a - i_op_b;
            OP_AND:  w_sc_res = i_op_a & i_op_b;
            OP_OR:   w_sc_res = i_op_a | i_op_b;
            OP_XOR:  w_sc_res = i_op_a ^ i_op_b;
            OP_SLL:  w_sc_res = i_op_a << i_op_b[4:0];
            OP_SRL:  w_sc_res = i_op_a >> i_op_b[4:0];
            OP_SRA:  w_sc_res = XLEN'($signed(i_op_a) >>> i_op_b[4:0]);
            OP_SLTU: w_sc_res = XLEN'(i_op_a < i_op_b);
            OP_SLT:  w_sc_res = XLEN'($signed(i_op_a) < $signed(i_op_b));
`ifdef ALU_EXEC_MULDIV_EN
            OP_MUL:  w_sc_res = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:
                     w_sc_res = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                if (i_op_b == '0)
                    w_sc_res = w_div_is_rem ? i_op_a : '1;
                else if (w_div_signed && i_op_a == INT_MIN && i_op_b == '1)
                    w_sc_res = w_div_is_rem ? '0 : INT_MIN;
                else
                    w_start_div = 1'b1;
            end
`endif
            default: w_sc_ill = 1'b1;
        endcase
    end

    assign o_in_ready = !i_rst && ((r_state == S_IDLE) ||
                                   ((r_state == S_DONE) && i_out_ready));
    assign w_accept   = i_in_valid && o_in_ready && !i_flush;

    always_comb begin
        w_state_nxt   = r_state;
        w_result_nxt  = r_result;
        w_illegal_nxt = r_illegal;
`ifdef ALU_EXEC_MULDIV_EN
        w_rem_nxt     = r_rem;
        w_quo_nxt     = r_quo;
        w_dvs_nxt     = r_dvs;
        w_cnt_nxt     = r_cnt;
        w_neg_q_nxt   = r_neg_q;
        w_neg_r_nxt   = r_neg_r;
        w_is_rem_nxt  = r_is_rem;
`endif
        if (i_flush) begin
            w_state_nxt = S_IDLE;
        end else if (w_accept) begin
`ifdef ALU_EXEC_MULDIV_EN
            if (w_start_div) begin
                w_state_nxt  = S_DIV;
                w_rem_nxt    = '0;
                w_quo_nxt    = w_abs_a;
                w_dvs_nxt    = w_abs_b;
                w_cnt_nxt    = '0;
                w_neg_q_nxt  = w_div_signed && (i_op_a[XLEN-1] ^ i_op_b[XLEN-1]);
                w_neg_r_nxt  = w_div_signed && i_op_a[XLEN-1];
                w_is_rem_nxt = w_div_is_rem;
            end else
`endif
            begin
                w_state_nxt   = S_DONE;
                w_result_nxt  = w_sc_res;
                w_illegal_nxt = w_sc_ill;
            end
        end else if (r_state == S_DONE && i_out_ready) begin
            w_state_nxt = S_IDLE;
`ifdef ALU_EXEC_MULDIV_EN
        end else if (r_state == S_DIV) begin
            w_rem_nxt = w_rem_step;
            w_quo_nxt = w_quo_step;
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(XLEN-1)) begin
                w_state_nxt   = S_DONE;
                w_result_nxt  = r_is_rem ? w_r_fin : w_q_fin;
                w_illegal_nxt = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_result  <= '0;
            r_illegal <= 1'b0;
`ifdef ALU_EXEC_MULDIV_EN
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_is_rem  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_result  <= w_result_nxt;
            r_illegal <= w_illegal_nxt;
`ifdef ALU_EXEC_MULDIV_EN
            r_rem     <= w_rem_nxt;
            r_quo     <= w_quo_nxt;
            r_dvs     <= w_dvs_nxt;
            r_cnt     <= w_cnt_nxt;
            r_neg_q   <= w_neg_q_nxt;
            r_neg_r   <= w_neg_r_nxt;
            r_is_rem  <= w_is_rem_nxt;
`endif
        end
    end

    assign o_out_valid = (r_state == S_DONE);
    assign o_result    = r_result;
    assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; expectations follow ALU_EXEC_MULDIV_EN.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, illegal, busy;
    logic [4:0]  alu_op;
    logic [31:0] op_a, op_b, result;
    int          total = 0;
    int          bad   = 0;

`ifdef ALU_EXEC_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    alu_exec_unit #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(in_ready), .i_alu_op(alu_op), .i_op_a(op_a), .i_op_b(op_b),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_result(result),
        .o_illegal(illegal), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Offer one op at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_op = op; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = '0; op_a = '0; op_b = '0;
        @(negedge clk); @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
        total++; if ({out_valid, illegal, busy} !== 3'b000) begin bad++; $display("FAIL post_rst_flags got=%b exp=000", {out_valid, illegal, busy}); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL post_rst_result got=%h exp=0", result); end
    endtask

    task automatic test_single_cycle;
        logic [4:0]  ops [16];
        logic [31:0] as  [16];
        logic [31:0] bs  [16];
        logic [31:0] exp [16];
        logic        ill [16];
        logic        md  [16];
        ops[0]='b00000; as[0]=5;            bs[0]=7;            exp[0]=32'd12;        ill[0]=0; md[0]=0;
        ops[1]='b00001; as[1]=3;            bs[1]=5;            exp[1]=32'hFFFFFFFE;  ill[1]=0; md[1]=0;
        ops[2]='b00100; as[2]=32'hF0F0;     bs[2]=32'h0FF0;     exp[2]=32'h00F0;      ill[2]=0; md[2]=0;
        ops[3]='b00101; as[3]=32'hF0F0;     bs[3]=32'h0FF0;     exp[3]=32'hFFF0;      ill[3]=0; md[3]=0;
        ops[4]='b00110; as[4]=32'hF0F0;     bs[4]=32'h0FF0;     exp[4]=32'hFF00;      ill[4]=0; md[4]=0;
        ops[5]='b00111; as[5]=1;            bs[5]=32'h23;       exp[5]=32'd8;         ill[5]=0; md[5]=0;
        ops[6]='b01001; as[6]=32'h80000000; bs[6]=4;            exp[6]=32'hF8000000;  ill[6]=0; md[6]=0;
        ops[7]='b01000; as[7]=32'h80000000; bs[7]=4;            exp[7]=32'h08000000;  ill[7]=0; md[7]=0;
        ops[8]='b01011; as[8]=32'hFFFFFFFF; bs[8]=1;            exp[8]=32'd1;         ill[8]=0; md[8]=0;
        ops[9]='b01010; as[9]=32'hFFFFFFFF; bs[9]=1;            exp[9]=32'd0;         ill[9]=0; md[9]=0;
        ops[10]='b11111; as[10]=9;          bs[10]=9;           exp[10]=32'd0;        ill[10]=1; md[10]=0;
        ops[11]='b01101; as[11]=32'hFFFFFFFF; bs[11]=32'hFFFFFFFF; exp[11]=32'h0;        ill[11]=0; md[11]=1;
        ops[12]='b10001; as[12]=32'hFFFFFFFF; bs[12]=32'hFFFFFFFF; exp[12]=32'hFFFFFFFE; ill[12]=0; md[12]=1;
        ops[13]='b10100; as[13]=32'hFFFFFFFF; bs[13]=2;            exp[13]=32'hFFFFFFFF; ill[13]=0; md[13]=1;
        ops[14]='b01100; as[14]=32'hFFFFFFFD; bs[14]=7;            exp[14]=32'hFFFFFFEB; ill[14]=0; md[14]=1;
        ops[15]='b01100; as[15]=3;            bs[15]=4;            exp[15]=32'd12;       ill[15]=0; md[15]=1;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] e_res;
            logic        e_ill;
            e_res = (md[i] && !MD) ? 32'h0 : exp[i];
            e_ill = (md[i] && !MD) ? 1'b1  : ill[i];
            issue(ops[i], as[i], bs[i]);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sc%0d_valid got=%b exp=1", i, out_valid); end
            total++; if (result !== e_res) begin bad++; $display("FAIL sc%0d_result got=%h exp=%h", i, result, e_res); end
            total++; if (illegal !== e_ill) begin bad++; $display("FAIL sc%0d_illegal got=%b exp=%b", i, illegal, e_ill); end
        end
        @(negedge clk);
    endtask

    task automatic test_div_timing;
        issue(5'b10010, 32'hFFFFFFF9, 32'd2);
        if (MD) begin
            for (int c = 1; c <= 32; c++) begin
                total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL div_busy_c%0d busy=%b valid=%b exp busy=1 valid=0", c, busy, out_valid); end
                @(negedge clk);
            end
            total++; if (out_valid !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL div_done valid=%b busy=%b exp valid=1 busy=0", out_valid, busy); end
            total++; if (result !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_result got=%h exp=fffffffd", result); end
        end else begin
            total++; if (out_valid !== 1'b1 || busy !== 1'b0 || illegal !== 1'b1 || result !== 32'h0) begin
                bad++; $display("FAIL div_nomd valid=%b busy=%b ill=%b res=%h exp 1 0 1 0", out_valid, busy, illegal, result);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_div_values;
        logic [4:0]  ops [12];
        logic [31:0] as  [12];
        logic [31:0] bs  [12];
        logic [31:0] exp [12];
        logic        one [12];
        ops[0]='b01110; as[0]=5;            bs[0]=0;            exp[0]=32'hFFFFFFFF; one[0]=1;
        ops[1]='b10010; as[1]=32'h80000000; bs[1]=32'hFFFFFFFF; exp[1]=32'h80000000; one[1]=1;
        ops[2]='b10011; as[2]=32'h80000000; bs[2]=32'hFFFFFFFF; exp[2]=32'h0;        one[2]=1;
        ops[3]='b01111; as[3]=9;            bs[3]=0;            exp[3]=32'd9;        one[3]=1;
        ops[4]='b10011; as[4]=32'hFFFFFFF9; bs[4]=0;            exp[4]=32'hFFFFFFF9; one[4]=1;
        ops[5]='b10010; as[5]=7;            bs[5]=0;            exp[5]=32'hFFFFFFFF; one[5]=1;
        ops[6]='b10011; as[6]=32'hFFFFFFF9; bs[6]=2;            exp[6]=32'hFFFFFFFF; one[6]=0;
        ops[7]='b10010; as[7]=20;           bs[7]=32'hFFFFFFFD; exp[7]=32'hFFFFFFFA; one[7]=0;
        ops[8]='b10011; as[8]=20;           bs[8]=32'hFFFFFFFD; exp[8]=32'd2;        one[8]=0;
        ops[9]='b01110; as[9]=100;          bs[9]=7;            exp[9]=32'd14;       one[9]=0;
        ops[10]='b01111; as[10]=100;        bs[10]=7;           exp[10]=32'd2;       one[10]=0;
        ops[11]='b01110; as[11]=32'hFFFFFFFF; bs[11]=1;         exp[11]=32'hFFFFFFFF; one[11]=0;
        for (int i = 0; i < 12; i++) begin
            logic [31:0] e_res;
            e_res = MD ? exp[i] : 32'h0;
            issue(ops[i], as[i], bs[i]);
            if (MD && !one[i]) begin
                for (int k = 0; k < 40 && out_valid !== 1'b1; k++) @(negedge clk);
            end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dv%0d_valid got=%b exp=1 (timeout or late)", i, out_valid); end
            total++; if (result !== e_res) begin bad++; $display("FAIL dv%0d_result got=%h exp=%h", i, result, e_res); end
            total++; if (illegal !== !MD) begin bad++; $display("FAIL dv%0d_illegal got=%b exp=%b", i, illegal, !MD); end
        end
        @(negedge clk);
    endtask

    task automatic test_hold;
        out_ready = 1'b0;
        issue(5'b00000, 32'd1, 32'd2);
        for (int c = 0; c < 5; c++) begin
            total++; if (out_valid !== 1'b1 || result !== 32'd3 || in_ready !== 1'b0) begin
                bad++; $display("FAIL hold_c%0d valid=%b res=%h rdy=%b exp 1 3 0", c, out_valid, result, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_retire valid=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back;
        alu_op = 5'b00000; op_a = 32'd100; op_b = 32'd0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op_b = 32'(i);
            @(posedge clk);
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || result !== 32'(100 + i) || in_ready !== 1'b1) begin
                bad++; $display("FAIL b2b_%0d valid=%b res=%h rdy=%b exp 1 %h 1", i, out_valid, result, in_ready, 32'(100 + i));
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush;
        if (MD) begin
            issue(5'b01110, 32'd100, 32'd3);
            for (int c = 1; c < 10; c++) @(negedge clk);
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_pre_busy got=%b exp=1", busy); end
            flush = 1'b1; in_valid = 1'b1; alu_op = 5'b00000; op_a = 1; op_b = 1;
            @(posedge clk);
            @(negedge clk);
            flush = 1'b0; in_valid = 1'b0;
            total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                bad++; $display("FAIL flush_div valid=%b busy=%b rdy=%b exp 0 0 1", out_valid, busy, in_ready);
            end
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_discard valid=%b exp=0", out_valid); end
        end
        out_ready = 1'b0;
        issue(5'b00000, 32'd4, 32'd4);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_done valid=%b rdy=%b exp 0 1", out_valid, in_ready);
        end
        issue(5'b00001, 32'd10, 32'd4);
        total++; if (out_valid !== 1'b1 || result !== 32'd6) begin
            bad++; $display("FAIL post_flush_op valid=%b res=%h exp 1 6", out_valid, result);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_div;
        issue(5'b01110, 32'd50, 32'd5);
        for (int c = 0; c < 5; c++) @(negedge clk);
        rst = 1'b1; flush = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid rdy=%b valid=%b busy=%b exp 0 0 0", in_ready, out_valid, busy);
        end
        rst = 1'b0; flush = 1'b0;
        @(negedge clk);
        total++; if (result !== 32'h0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid_after res=%h rdy=%b exp 0 1", result, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_div_timing();
        test_div_values();
        test_hold();
        test_back_to_back();
        test_flush();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
